// File: rtl/muldiv_hilo_if.sv
// muldiv_hilo_if: bundles the EX-stage HI/LO request, the divider handshake and the
// architectural HI/LO outputs of muldiv_hilo_ctrl.
//   slave  : the controller (consumes requests and divider results, drives HI/LO/stall).
//   master : pipeline + divider side (drives requests, kill/hold and div_ready/div_result).
interface muldiv_hilo_if;
   logic        req_valid;
   logic [2:0]  req_kind;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        flush_exc;
   logic        hold;
   logic        div_start;
   logic        div_signed;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic        div_annul;
   logic        div_ready;
   logic [63:0] div_result;
   logic        stall_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        commit_o;

   modport slave (
      input  req_valid, req_kind, a, b, flush, flush_exc, hold, div_ready, div_result,
      output div_start, div_signed, div_a, div_b, div_annul, stall_o, hi_o, lo_o, commit_o
   );

   modport master (
      output req_valid, req_kind, a, b, flush, flush_exc, hold, div_ready, div_result,
      input  div_start, div_signed, div_a, div_b, div_annul, stall_o, hi_o, lo_o, commit_o
   );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: HI/LO owner and MULT/DIV sequencer for the EX stage.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - muldiv_hilo_if.slave: request (req_valid/req_kind/a/b), kill (flush/flush_exc),
//          hold, divider handshake (div_start/div_signed/div_a/div_b/div_annul/div_ready/
//          div_result), stall_o, hi_o/lo_o, commit_o.
// Multiplies complete in MUL_LAT stall cycles on an internal product; divides run on the
// external divider. HI/LO are written once per instruction in DONE unless killed.
module muldiv_hilo_ctrl #(
   parameter int unsigned MUL_LAT = 2
) (
   input logic          clk,
   input logic          rst,
   muldiv_hilo_if.slave bus
);

   localparam logic [2:0] KindMult  = 3'd0;
   localparam logic [2:0] KindMultu = 3'd1;
   localparam logic [2:0] KindDiv   = 3'd2;
   localparam logic [2:0] KindDivu  = 3'd3;
   localparam logic [2:0] KindMthi  = 3'd4;
   localparam logic [2:0] KindMtlo  = 3'd5;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] res_q, res_d;
   logic        nowrite_q, nowrite_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        div_start_q, div_start_d;
   logic        div_signed_q, div_signed_d;
   logic [31:0] div_a_q, div_a_d;
   logic [31:0] div_b_q, div_b_d;

   logic        kill;
   logic        is_mul;
   logic        is_div;
   logic        is_mt;
   logic [63:0] product;

   assign kill   = bus.flush | bus.flush_exc;
   assign is_mul = bus.req_valid & ((bus.req_kind == KindMult) | (bus.req_kind == KindMultu));
   assign is_div = bus.req_valid & ((bus.req_kind == KindDiv) | (bus.req_kind == KindDivu));
   assign is_mt  = bus.req_valid & ((bus.req_kind == KindMthi) | (bus.req_kind == KindMtlo));

   always_comb begin
      if (bus.req_kind == KindMult) begin
         product = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
      end else begin
         product = {32'd0, bus.a} * {32'd0, bus.b};
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         res_q        <= '0;
         nowrite_q    <= 1'b0;
         hi_q         <= '0;
         lo_q         <= '0;
         div_start_q  <= 1'b0;
         div_signed_q <= 1'b0;
         div_a_q      <= '0;
         div_b_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         res_q        <= res_d;
         nowrite_q    <= nowrite_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         div_start_q  <= div_start_d;
         div_signed_q <= div_signed_d;
         div_a_q      <= div_a_d;
         div_b_q      <= div_b_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      res_d        = res_q;
      nowrite_d    = nowrite_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      div_start_d  = 1'b0;
      div_signed_d = div_signed_q;
      div_a_d      = div_a_q;
      div_b_d      = div_b_q;
      unique case (state_q)
         StIdle: begin
            if (!kill) begin
               if (is_mt) begin
                  if (bus.req_kind == KindMthi) hi_d = bus.a;
                  else                          lo_d = bus.a;
               end else if (is_mul) begin
                  res_d     = product;
                  nowrite_d = 1'b0;
                  if (MUL_LAT == 1) begin
                     state_d = StDone;
                  end else begin
                     cnt_d   = 4'(MUL_LAT - 1);
                     state_d = StMul;
                  end
               end else if (is_div) begin
                  if (bus.b != '0) begin
                     // Start is registered so it lines up with the registered operands.
                     div_start_d  = 1'b1;
                     div_a_d      = bus.a;
                     div_b_d      = bus.b;
                     div_signed_d = (bus.req_kind == KindDiv);
                     state_d      = StDiv;
                  end else begin
                     nowrite_d = 1'b1;
                     state_d   = StDone;
                  end
               end
            end
         end
         StMul: begin
            if (kill)              state_d = StIdle;
            else if (cnt_q == 4'd1) state_d = StDone;
            else                   cnt_d   = cnt_q - 4'd1;
         end
         StDiv: begin
            if (kill) begin
               state_d = StIdle;
            end else if (bus.div_ready) begin
               res_d     = bus.div_result;
               nowrite_d = 1'b0;
               state_d   = StDone;
            end
         end
         StDone: begin
            if (kill) begin
               state_d = StIdle;
            end else if (!bus.hold) begin
               if (!nowrite_q) begin
                  hi_d = res_q[63:32];
                  lo_d = res_q[31:0];
               end
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      bus.stall_o   = ((state_q == StIdle) & (is_mul | is_div) & ~kill)
                      | (state_q == StMul) | (state_q == StDiv);
      bus.commit_o  = ~rst & ~kill & (((state_q == StIdle) & is_mt)
                      | ((state_q == StDone) & ~bus.hold & ~nowrite_q));
      // Reset does not annul: the divider is reset alongside this block.
      bus.div_annul = ~rst & kill & (state_q == StDiv);
   end

   assign bus.div_start  = div_start_q;
   assign bus.div_signed = div_signed_q;
   assign bus.div_a      = div_a_q;
   assign bus.div_b      = div_b_q;
   assign bus.hi_o       = hi_q;
   assign bus.lo_o       = lo_q;

endmodule

// File: doc/muldiv_hilo_ctrl.md
# muldiv_hilo_ctrl

Sequencer and owner of the HI/LO register pair for the EX stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests and runs multiplies on an internal latency-modelled multiplier. Drives the external iterative divider through a start/ready handshake. Stalls the pipeline while an operation is in flight, and commits HI/LO exactly once per instruction unless the instruction is flushed.

## Interface
- MUL_LAT, 2, multiply latency in stall cycles; legal range 1..15.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  EX holds a HI/LO-class instruction; held stable while stall_o=1.
- req_kind  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6..7 are ignored, treated as no request.
- a, b  in  32 each  operands (rs, rt).
- flush  in  1  EX flush (FlushE).
- flush_exc  in  1  exception flush from MEM.
- hold  in  1  downstream stall; freezes commit.
- div_start  out  1  one-cycle start pulse to the divider.
- div_signed  out  1  1 for DIV; registered with the operands.
- div_a, div_b  out  32 each  registered divider operands.
- div_annul  out  1  one-cycle abort pulse to the divider.
- div_ready  in  1  one-cycle pulse: div_result valid.
- div_result  in  64  {remainder, quotient}.
- stall_o  out  1  stall request to the pipeline.
- hi_o, lo_o  out  32 each  architectural HI/LO registers.
- commit_o  out  1  pulse in the cycle HI/LO are written.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset → IDLE; hi_o=lo_o=0; cnt=0; res_q=0; every pulse output=0; div_a=div_b=0.
- Abort condition: kill = flush | flush_exc. Priority is rst > kill > normal operation.
- IDLE, MTHI/MTLO with ~kill: on the clock edge, hi_o←a (MTHI) or lo_o←a (MTLO); commit_o=1; no stall; stay IDLE.
- IDLE, MULT/MULTU with ~kill: capture res_q ← signed (MULT) or zero-extended (MULTU) 64-bit product of a and b.
  - If MUL_LAT=1, go to DONE.
  - Otherwise load cnt=MUL_LAT-1 and go to MUL.
- IDLE, DIV/DIVU with ~kill, b≠0: div_start=1; latch div_a, div_b, div_signed; go to DIV.
- IDLE, DIV/DIVU with ~kill, b=0: go to DONE with a no-write flag set. HI/LO are left unchanged; commit_o stays 0.
- MUL: if cnt==1, go to DONE; otherwise cnt decrements.
- DIV: wait for div_ready. On div_ready, res_q ← div_result (hi=remainder, lo=quotient) and go to DONE. div_ready seen in any other state is ignored.
- DONE with ~hold & ~kill: {hi_o,lo_o} ← res_q (skipped when the no-write flag is set); commit_o=1; go to IDLE.
  - req_valid in this cycle is the same instruction and must not be re-issued.
- DONE with hold & ~kill: stay in DONE with no write.
- kill in MUL, DIV or DONE: go to IDLE with no HI/LO write.
- kill in DIV additionally drives div_annul=1 for one cycle.
- kill in IDLE: the request is dropped; nothing is written and no stall is raised.
- stall_o = (IDLE & req_valid & kind∈{0..3} & ~kill) | MUL | DIV. stall_o is 0 in DONE.
- Products are computed full-width: 64-bit signed via $signed for MULT, unsigned for MULTU. No overflow signal.

## Timing
- stall_o is combinational from the request in IDLE and registered-state based otherwise.
- MULT: stall_o is high for exactly MUL_LAT cycles (the issue cycle counts as cycle 0). DONE is in cycle MUL_LAT. New HI/LO is visible in cycle MUL_LAT+1.
- DIV: stall_o is high from the issue cycle through the div_ready cycle. DONE is the cycle after div_ready.
- MTHI/MTLO: the value is visible on hi_o/lo_o the cycle after the request.
- A back-to-back request arriving in the cycle after DONE is issued normally from IDLE.
- Reset asserted mid-operation: all state returns to reset values on the next edge. div_annul is not pulsed; the divider shares rst.

## Test plan
- Signed multiply, MUL_LAT=2: MULT a=0xFFFF_FFFE, b=3 → stall_o high for cycles 0–1; commit_o in cycle 2; then hi_o=0xFFFF_FFFF, lo_o=0xFFFF_FFFA.
- Unsigned divide: DIVU a=100, b=7 with div_ready in cycle 34 → stall_o high for cycles 0–34; commit in cycle 35; hi_o=2, lo_o=14; div_start pulsed once.
- Flush mid-divide: DIV issued, flush in cycle 10 → div_annul pulse in cycle 10; IDLE in cycle 11; HI/LO unchanged; a late div_ready in cycle 34 is ignored.
- Hold in DONE: MULTU a=b=0xFFFF_FFFF with hold=1 for 3 cycles in DONE → no commit until hold drops; then hi_o=0xFFFF_FFFE, lo_o=0x0000_0001 with a single commit_o pulse.
- MTHI then MTLO back-to-back: a=0x1234_5678 then a=0x9ABC_DEF0 → no stall; hi_o and lo_o each update one cycle after their request; flush_exc on the MTLO cycle blocks the lo_o write.
- Divide by zero plus reset: DIV with b=0 → one stall cycle, no commit, HI/LO unchanged, no div_start. Then rst during MUL state → hi_o=lo_o=0, stall_o=0 the next cycle.
